btn_cond_n: RTL and testbench
=============================

# btn_cond_n

Parametrised multi-channel push-button conditioner for the Nexys3 lab tops. It synchronises raw button inputs and down-samples them on a shared divided clock-enable. It debounces each channel over a configurable sample depth and emits one-cycle press and release pulses, with optional per-channel hold-to-auto-repeat. It also keeps a wrapping per-channel event counter for LED display. It replaces ad-hoc per-button shift-register debouncing in the top level and feeds instruction-valid strobes to downstream sequencers.

## Interface
Parameters:
- N_CH, 4: number of button channels (>=1).
- DIV_W, 17: sample divider width; one sample tick every 2^DIV_W clk cycles (>=1).
- DEPTH, 3: consecutive agreeing samples required to change debounced level (>=2).
- RPT_DLY, 32: ticks a button must be held before the first repeat pulse (>=1).
- RPT_PER, 8: ticks between subsequent repeat pulses (>=1).
- CNT_W, 8: width of each event counter.

Ports:
- clk  in  1  system clock (100 MHz).
- arst_i  in  1  reset, asynchronous, active-high; clock clk.
- btn_i  in  N_CH  raw asynchronous button levels.
- rpt_en_i  in  N_CH  per-channel auto-repeat enable (synchronous to clk).
- clr_i  in  1  synchronous clear of all event counters.
- tick_o  out  1  one-cycle sample strobe.
- level_o  out  N_CH  debounced button level.
- rise_o  out  N_CH  one-cycle press/repeat pulse.
- fall_o  out  N_CH  one-cycle release pulse.
- any_o  out  1  OR of rise_o (combinational).
- cnt_o  out  N_CH*CNT_W  event counters; channel k at bits [k*CNT_W +: CNT_W].

## Operation
- Every flop is reset by arst_i to 0. This includes the synchroniser, divider, shift registers, level, pulses, repeat counters and event counters.
- Synchroniser: two flops per channel on btn_i. Only the second flop feeds the rest of the logic.
- Divider: a DIV_W-bit free-running counter. tick_o is registered and is high for one cycle each time the counter wraps from all-ones to 0.
- Sample shift: on each tick_o cycle, each channel shifts its synchronised bit into a DEPTH-bit shift register.
- Debounce: on the cycle after a tick, level updates.
  - If the register is all ones, level goes to 1.
  - If the register is all zeros, level goes to 0.
  - Otherwise level holds.
- rise_o[k] and fall_o[k] are registered together with level_o and mark its 0->1 and 1->0 transitions. Each pulse is exactly one cycle wide.
- Auto-repeat, per channel: a tick counter wide enough for max(RPT_DLY, RPT_PER).
  - The counter is held at 0 whenever level_o[k]=0 or rpt_en_i[k]=0.
  - Otherwise it increments on every tick while the level is held.
  - When the count reaches RPT_DLY (first repeat) or RPT_PER (later repeats), rise_o[k] pulses. The pulse is aligned one cycle after the tick, the same alignment as a press pulse. The counter then reloads to 0.
  - Dropping rpt_en_i mid-hold stops repeats immediately. Re-asserting it restarts the RPT_DLY wait.
- Event counter: increments by 1 per rise_o[k] pulse, including repeats, and wraps modulo 2^CNT_W. clr_i has priority: all counters go to 0, and any rise in that same cycle is not counted.
- Glitches shorter than DEPTH consecutive ticks never change level_o and never produce pulses.

## Timing
- Reset values: all outputs 0. any_o is 0 because rise_o is 0.
- First tick_o occurs 2^DIV_W cycles after arst_i deasserts. After that, tick_o is strictly periodic with period 2^DIV_W.
- Press latency: once btn_i is stable, it takes 2 cycles of sync, then DEPTH ticks, then 1 cycle until level_o and rise_o change. The worst case is 2 + DEPTH*2^DIV_W + 1 cycles.
- Release latency is symmetric for fall_o.
- rise_o and fall_o on the same channel are never high in the same cycle. Different channels are fully independent.
- Simultaneous press on several channels gives concurrent rise_o bits. any_o is high for that one cycle.
- arst_i asserted mid-hold: outputs clear immediately. A button still held after reset release is re-detected as a fresh press, with full press latency and RPT_DLY restarting.
- clr_i takes effect at the next clk edge and has no effect on level, pulse or repeat state.

## Test plan
Parameters for all scenarios: N_CH=4, DIV_W=2, DEPTH=3, RPT_DLY=4, RPT_PER=2, CNT_W=4.
1. Reset: apply arst_i, then release it, with btn_i=0 -> all outputs 0. First tick_o at cycle 4 after release, then every 4 cycles.
2. Hold btn_i[0]=1 for 40 cycles, then release with rpt_en_i=0 -> exactly one rise_o[0] pulse, level_o[0]=1, cnt ch0=1. After release: one fall_o[0] pulse, level_o[0]=0, cnt unchanged.
3. btn_i[1] high for 2 ticks only (8 cycles) -> level_o[1] stays 0, no pulses, cnt ch1=0.
4. Hold btn_i[2] with rpt_en_i[2]=1 -> rise_o[2] at press, again 4 ticks later, then every 2 ticks. After 16 rise pulses cnt ch2 wraps to 0. Dropping rpt_en_i[2] mid-hold stops pulses.
5. Assert clr_i in the same cycle as a rise_o[3] pulse -> cnt ch3=0 next cycle. rise_o[3] and level_o[3] are unaffected.
6. Assert arst_i while btn_i[0] is held with level_o[0]=1 -> all outputs 0 at once. After release, rise_o[0] fires again after the full press latency.

Source files
------------

// File: rtl/btn_cond_n.sv
// Multi-channel push-button conditioner: synchronise, sample on a divided tick,
// debounce, emit press/release/auto-repeat pulses and keep wrapping event counters.
module btn_cond_n #(
  parameter int N_CH    = 4,
  parameter int DIV_W   = 17,
  parameter int DEPTH   = 3,
  parameter int RPT_DLY = 32,
  parameter int RPT_PER = 8,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    arst_i,
  input  logic [N_CH-1:0]         btn_i,
  input  logic [N_CH-1:0]         rpt_en_i,
  input  logic                    clr_i,
  output logic                    tick_o,
  output logic [N_CH-1:0]         level_o,
  output logic [N_CH-1:0]         rise_o,
  output logic [N_CH-1:0]         fall_o,
  output logic                    any_o,
  output logic [N_CH*CNT_W-1:0]   cnt_o
);

  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DLY_C = RW'(RPT_DLY);
  localparam logic [RW-1:0] PER_C = RW'(RPT_PER);

  logic [N_CH-1:0]            sync1_q, sync1_d;
  logic [N_CH-1:0]            sync2_q, sync2_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic                       tick_q, tick_d;
  logic [N_CH-1:0][DEPTH-1:0] shift_q, shift_d;
  logic [N_CH-1:0]            level_q, level_d;
  logic [N_CH-1:0]            rise_q, rise_d;
  logic [N_CH-1:0]            fall_q, fall_d;
  logic [N_CH-1:0][RW-1:0]    rpt_q, rpt_d;
  logic [N_CH-1:0][RW-1:0]    rpt_inc_s;
  logic [N_CH-1:0]            seen_q, seen_d;
  logic [N_CH-1:0]            fire_s;
  logic [N_CH-1:0][CNT_W-1:0] evt_q, evt_d;

  // Input synchroniser, free-running sample divider and registered tick.
  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    div_d   = div_q + DIV_W'(1);
    tick_d  = &div_q;
  end

  // Sample shift and debounced level; the level follows a full run of agreeing samples.
  always_comb begin
    shift_d = shift_q;
    level_d = level_q;
    if (tick_q) begin
      for (int k = 0; k < N_CH; k++) begin
        shift_d[k] = {shift_q[k][DEPTH-2:0], sync2_q[k]};
        if (&shift_d[k]) begin
          level_d[k] = 1'b1;
        end else if (~|shift_d[k]) begin
          level_d[k] = 1'b0;
        end else begin
          level_d[k] = level_q[k];
        end
      end
    end else begin
      shift_d = shift_q;
      level_d = level_q;
    end
  end

  // Auto-repeat tick counters; seen marks that the first (long) delay has elapsed.
  always_comb begin
    rpt_d     = rpt_q;
    seen_d    = seen_q;
    fire_s    = '0;
    rpt_inc_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      rpt_inc_s[k] = rpt_q[k] + RW'(1);
      // A release on this tick must not also produce a repeat pulse.
      if (!level_q[k] || !rpt_en_i[k] || !level_d[k]) begin
        rpt_d[k]  = '0;
        seen_d[k] = 1'b0;
      end else if (tick_q) begin
        if (rpt_inc_s[k] == (seen_q[k] ? PER_C : DLY_C)) begin
          fire_s[k] = 1'b1;
          rpt_d[k]  = '0;
          seen_d[k] = 1'b1;
        end else begin
          rpt_d[k]  = rpt_inc_s[k];
          seen_d[k] = seen_q[k];
        end
      end else begin
        rpt_d[k]  = rpt_q[k];
        seen_d[k] = seen_q[k];
      end
    end
  end

  // Edge pulses registered alongside the level they describe.
  always_comb begin
    rise_d = (level_d & ~level_q) | fire_s;
    fall_d = level_q & ~level_d;
  end

  // Wrapping event counters; clear wins over a concurrent rise.
  always_comb begin
    evt_d = evt_q;
    for (int k = 0; k < N_CH; k++) begin
      if (clr_i) begin
        evt_d[k] = '0;
      end else if (rise_q[k]) begin
        evt_d[k] = evt_q[k] + CNT_W'(1);
      end else begin
        evt_d[k] = evt_q[k];
      end
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
      shift_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      rpt_q   <= '0;
      seen_q  <= '0;
      evt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      shift_q <= shift_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      rpt_q   <= rpt_d;
      seen_q  <= seen_d;
      evt_q   <= evt_d;
    end
  end

  assign tick_o  = tick_q;
  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign any_o   = |rise_q;
  assign cnt_o   = evt_q;

endmodule

// File: tb/tb_btn_cond_n.sv
// Bench for btn_cond_n: cycle-by-cycle comparison against a sample-history model,
// plus directed scenarios with hand-computed expectations.
module tb_btn_cond_n;

  localparam int N_CH = 4, DIV_W = 2, DEPTH = 3, RPT_DLY = 4, RPT_PER = 2, CNT_W = 4;

  logic        clk = 1'b0;
  logic        arst_i = 1'b1;
  logic        clr_i = 1'b0;
  logic [3:0]  btn_i = 4'b0000;
  logic [3:0]  rpt_en_i = 4'b0000;
  logic        tick_o, any_o;
  logic [3:0]  level_o, rise_o, fall_o;
  logic [15:0] cnt_o;

  int n_pass = 0;
  int n_total = 0;
  int rc[4];
  int fc[4];

  btn_cond_n #(
    .N_CH(N_CH), .DIV_W(DIV_W), .DEPTH(DEPTH),
    .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .arst_i(arst_i), .btn_i(btn_i), .rpt_en_i(rpt_en_i), .clr_i(clr_i),
    .tick_o(tick_o), .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
    .any_o(any_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: keeps the last DEPTH samples of each button and counts held ticks.
  bit [3:0] m_d1, m_d2;
  bit       m_q[4][$];
  bit [3:0] m_level, m_rise, m_fall;
  bit       m_tick;
  int       m_held[4];
  bit       m_seen[4];
  int       m_cnt[4];
  int       m_cyc;

  initial begin
    forever begin
      @(posedge clk or posedge arst_i);
      if (arst_i) begin
        m_d1 = '0; m_d2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
        m_tick = 1'b0; m_cyc = 0;
        for (int k = 0; k < 4; k++) begin
          m_q[k] = '{1'b0, 1'b0, 1'b0};
          m_held[k] = 0; m_seen[k] = 1'b0; m_cnt[k] = 0;
        end
      end else begin
        bit [3:0] nl, nr, nf;
        nl = m_level; nr = '0; nf = '0;
        for (int k = 0; k < 4; k++) begin
          bit fire;
          int ones;
          fire = 1'b0;
          if (m_tick) begin
            m_q[k].push_back(m_d2[k]);
            if (m_q[k].size() > DEPTH) void'(m_q[k].pop_front());
            ones = 0;
            foreach (m_q[k][i]) ones += m_q[k][i];
            if (ones == DEPTH) nl[k] = 1'b1;
            else if (ones == 0) nl[k] = 1'b0;
          end
          if (!m_level[k] || !rpt_en_i[k] || !nl[k]) begin
            m_held[k] = 0; m_seen[k] = 1'b0;
          end else if (m_tick) begin
            m_held[k]++;
            if (m_held[k] == (m_seen[k] ? RPT_PER : RPT_DLY)) begin
              fire = 1'b1; m_held[k] = 0; m_seen[k] = 1'b1;
            end
          end
          nr[k] = (nl[k] && !m_level[k]) || fire;
          nf[k] = m_level[k] && !nl[k];
          m_cnt[k] = clr_i ? 0 : (m_cnt[k] + int'(m_rise[k])) % 16;
        end
        m_level = nl; m_rise = nr; m_fall = nf;
        m_cyc++;
        m_tick = (m_cyc % (1 << DIV_W) == 0);
        m_d2 = m_d1; m_d1 = btn_i;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    @(posedge clk);
    forever begin
      logic [15:0] ec;
      @(negedge clk);
      for (int k = 0; k < 4; k++) ec[k*4 +: 4] = m_cnt[k][3:0];
      chk("cycle", {2'b00, tick_o, any_o, level_o, rise_o, fall_o, cnt_o},
          {2'b00, m_tick, |m_rise, m_level, m_rise, m_fall, ec});
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        rc[k] += int'(rise_o[k]);
        fc[k] += int'(fall_o[k]);
      end
    end
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 4; k++) begin
      rc[k] = 0; fc[k] = 0;
    end
  endtask

  initial begin
    int t[16];
    int n;
    int cyc;
    bit found;

    // 1: reset release, tick phase
    repeat (3) @(negedge clk);
    #2 arst_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("tick_phase", {31'd0, tick_o}, {31'd0, (i % 4 == 0)});
      if (i == 1) chk("reset_outs", {any_o, level_o, rise_o, fall_o, cnt_o}, 29'd0);
    end

    // 2: single press and release on ch0, no repeat
    clr_counts();
    btn_i[0] = 1'b1;
    run(40);
    chk("s2_rise_n", rc[0], 1);
    chk("s2_level", {31'd0, level_o[0]}, 32'd1);
    chk("s2_cnt0", {28'd0, cnt_o[3:0]}, 32'd1);
    clr_counts();
    btn_i[0] = 1'b0;
    run(40);
    chk("s2_fall_n", fc[0], 1);
    chk("s2_rise_n2", rc[0], 0);
    chk("s2_level0", {31'd0, level_o[0]}, 32'd0);
    chk("s2_cnt0_kept", {28'd0, cnt_o[3:0]}, 32'd1);

    // 3: glitch of two samples on ch1
    clr_counts();
    btn_i[1] = 1'b1;
    run(8);
    btn_i[1] = 1'b0;
    run(20);
    chk("s3_pulses", rc[1] + fc[1], 0);
    chk("s3_level", {31'd0, level_o[1]}, 32'd0);
    chk("s3_cnt1", {28'd0, cnt_o[7:4]}, 32'd0);

    // 4: auto-repeat on ch2, counter wrap, stop on enable drop
    rpt_en_i[2] = 1'b1;
    btn_i[2] = 1'b1;
    n = 0; cyc = 0;
    for (int k = 0; k < 16; k++) t[k] = 0;
    while (n < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (rise_o[2]) begin
        t[n] = cyc;
        n++;
      end
    end
    chk("s4_rise_n", n, 16);
    chk("s4_first_gap", t[1] - t[0], 16);
    chk("s4_second_gap", t[2] - t[1], 8);
    chk("s4_last_gap", t[15] - t[14], 8);
    @(negedge clk);
    chk("s4_cnt2_wrap", {28'd0, cnt_o[11:8]}, 32'd0);
    rpt_en_i[2] = 1'b0;
    clr_counts();
    run(40);
    chk("s4_no_rpt", rc[2], 0);
    chk("s4_level", {31'd0, level_o[2]}, 32'd1);
    btn_i[2] = 1'b0;
    run(40);
    chk("s4_fall_n", fc[2], 1);

    // 5: clear in the same cycle as a rise on ch3
    btn_i[3] = 1'b1;
    run(40);
    btn_i[3] = 1'b0;
    run(40);
    chk("s5_cnt3_pre", {28'd0, cnt_o[15:12]}, 32'd1);
    btn_i[3] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (rise_o[3]) found = 1'b1;
    end
    chk("s5_rise_seen", {31'd0, found}, 32'd1);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    chk("s5_cnt3", {28'd0, cnt_o[15:12]}, 32'd0);
    chk("s5_cnt0", {28'd0, cnt_o[3:0]}, 32'd0);
    chk("s5_level3", {31'd0, level_o[3]}, 32'd1);
    btn_i[3] = 1'b0;
    run(40);

    // 6: reset while ch0 is held, then re-detection with full latency
    btn_i[0] = 1'b1;
    run(40);
    chk("s6_level_pre", {31'd0, level_o[0]}, 32'd1);
    #2 arst_i = 1'b1;
    #1;
    chk("s6_rst_outs", {tick_o, any_o, level_o, rise_o, fall_o, cnt_o}, 30'd0);
    @(negedge clk);
    @(negedge clk);
    #2 arst_i = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      chk("s6_rise_lat", {31'd0, rise_o[0]}, {31'd0, (i == 13)});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
